pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register for the ARM core pipeline, generalising the fixed-width IF/ID register. It carries a DATA_W-bit payload between adjacent stages under a valid/ready handshake. Flush (branch taken) and freeze (hazard stall) behave as in the existing stage registers. An optional 2-entry skid buffer breaks the combinational ready path so backpressure can be applied without losing beats.

## Interface
- DATA_W, 64 — payload width; e.g. {pc, inst} for IF/ID.
- FLUSH_VAL, {DATA_W{1'b0}} — payload value loaded on reset and flush; acts as the NOP/bubble value.

Ports:
- clk  in  1  — single clock; all state updates on the rising edge.
- rst  in  1  — reset, asynchronous, active-high.
- in_valid  in  1  — upstream beat is valid.
- in_ready  out  1  — stage accepts a beat this cycle.
- in_data  in  DATA_W  — upstream payload.
- out_valid  out  1  — downstream beat is valid.
- out_ready  in  1  — downstream accepts a beat this cycle.
- out_data  out  DATA_W  — payload of the head entry.
- flush  in  1  — discard all held and incoming beats.
- freeze  in  1  — hold contents; no transfer on either side.
- occupancy  out  2  — number of held entries: 0..2 with skid, 0..1 without.

## Operation
- State:
  - main entry: M, valid mv.
  - skid entry: S, valid sv (skid build only).
- Input transfer: in_fire = in_valid & in_ready.
- Output transfer: out_fire = out_valid & out_ready.
- out_valid = mv & ~freeze.
- out_data = M at all times, including while not valid.
- Priority, highest first: rst, flush, freeze, normal.
- Flush:
  - Next edge: mv <= 0, sv <= 0, M <= FLUSH_VAL.
  - A beat accepted in the same cycle is dropped.
  - A downstream fire in the same cycle still counts as delivered.
- Freeze without flush:
  - in_ready = 0; out_valid = 0.
  - M, S, mv and sv are unchanged.
- Normal operation, skid build:
  - in_ready = ~sv & ~freeze. This is registered state only, with no dependence on out_ready.
  - out_fire with sv = 1: M <= S, sv <= 0.
  - out_fire with sv = 0 and in_fire: M <= in_data, mv stays 1.
  - out_fire with sv = 0 and no in_fire: mv <= 0.
  - No out_fire, in_fire, mv = 0: M <= in_data, mv <= 1.
  - No out_fire, in_fire, mv = 1: S <= in_data, sv <= 1.
- Normal operation, non-skid build:
  - in_ready = ~freeze & (~mv | out_ready). This path is combinational.
  - in_fire: M <= in_data, mv <= 1.
  - out_fire without in_fire: mv <= 0.
- Beats leave in strict acceptance order. No duplication and no loss except by flush.
- occupancy = mv + sv.

## Timing
- Reset values:
  - out_valid = 0; out_data = FLUSH_VAL; occupancy = 0.
  - in_ready = 1 after rst deasserts, with freeze low.
- Latency from accept to out_valid: 1 cycle.
- Throughput: 1 beat/cycle sustained while out_ready = 1.
- Skid build, out_ready low:
  - accepts 2 beats, then in_ready drops the cycle after sv sets.
  - in_ready rises the cycle after the first out_fire that empties S.
- Reset asserted mid-transfer: all entries cleared immediately, asynchronously; no beat is delivered afterward.
- Freeze and flush both high: flush wins and freeze is ignored for that edge.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - skid entry present.
  - in_ready is registered.
  - occupancy ranges 0..2.
- PIPE_STAGE_SKID_EN undefined:
  - single entry.
  - in_ready depends combinationally on out_ready and freeze.
  - occupancy ranges 0..1; occupancy[1] is tied to 0.

## Test plan
- Reset then stream: DATA_W=64, out_ready=1, send 0x1..0x8 on consecutive cycles -> out_data is 0x1..0x8 in order, each 1 cycle after acceptance, out_valid continuously high.
- Backpressure (skid): out_ready=0, offer 0xA, 0xB, 0xC -> 0xA and 0xB accepted, in_ready=0 while 0xC is held off, occupancy=2; raise out_ready -> 0xA, 0xB, 0xC delivered in order.
- Flush with full stage: occupancy=2, pulse flush with in_valid=1 and in_data=0xD -> next cycle occupancy=0, out_valid=0, out_data=FLUSH_VAL; 0xD is never delivered.
- Freeze: held beat 0x5, freeze high for 3 cycles -> out_valid=0 and in_ready=0 throughout, occupancy unchanged; after freeze drops, 0x5 is delivered once.
- Flush and freeze together while holding 0x7 -> flush takes effect: entries cleared, out_data=FLUSH_VAL.
- Async reset mid-stream: assert rst between clock edges while holding 0x9 -> out_valid=0 and out_data=FLUSH_VAL immediately, without waiting for an edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with a valid/ready
// handshake, flush (branch taken) and freeze (hazard stall).
//
// Build option: define PIPE_STAGE_SKID_EN to add a second (skid) entry.
// This makes in_ready a registered signal, so backpressure from out_ready
// no longer ripples combinationally upstream. Without the macro the stage
// has a single entry, and in_ready depends on out_ready in the same cycle.
//
// Priority, highest first: rst, flush, freeze, normal transfer.
// out_data always shows the main entry, even while out_valid is low.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              freeze,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] m_q, m_d;
  logic              mv_q, mv_d;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = mv_q & ~freeze;
  assign out_data  = m_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN

  logic [DATA_W-1:0] s_q, s_d;
  logic              sv_q, sv_d;

  // The skid entry being full is the only thing that stops acceptance,
  // so in_ready never looks at out_ready.
  assign in_ready  = ~sv_q & ~freeze;
  assign occupancy = {1'b0, mv_q} + {1'b0, sv_q};

  // Next-state: the skid entry refills main on a pop, otherwise new beats
  // land in main if it is empty and in skid if main is occupied.
  always_comb begin
    m_d  = m_q;
    mv_d = mv_q;
    s_d  = s_q;
    sv_d = sv_q;
    if (flush) begin
      m_d  = FLUSH_VAL;
      mv_d = 1'b0;
      sv_d = 1'b0;
    end else if (!freeze) begin
      if (out_fire) begin
        if (sv_q) begin
          m_d  = s_q;
          sv_d = 1'b0;
        end else if (in_fire) begin
          m_d = in_data;
        end else begin
          mv_d = 1'b0;
        end
      end else if (in_fire) begin
        if (!mv_q) begin
          m_d  = in_data;
          mv_d = 1'b1;
        end else begin
          s_d  = in_data;
          sv_d = 1'b1;
        end
      end
    end
  end

  // State register; reset clears both entries immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q  <= FLUSH_VAL;
      mv_q <= 1'b0;
      s_q  <= FLUSH_VAL;
      sv_q <= 1'b0;
    end else begin
      m_q  <= m_d;
      mv_q <= mv_d;
      s_q  <= s_d;
      sv_q <= sv_d;
    end
  end

`else

  // Single entry: an occupied stage accepts only when its beat leaves this cycle.
  assign in_ready  = ~freeze & (~mv_q | out_ready);
  assign occupancy = {1'b0, mv_q};

  // Next-state: a new beat always overwrites main; a pop without refill empties it.
  always_comb begin
    m_d  = m_q;
    mv_d = mv_q;
    if (flush) begin
      m_d  = FLUSH_VAL;
      mv_d = 1'b0;
    end else if (!freeze) begin
      if (in_fire) begin
        m_d  = in_data;
        mv_d = 1'b1;
      end else if (out_fire) begin
        mv_d = 1'b0;
      end
    end
  end

  // State register; reset clears the entry immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q  <= FLUSH_VAL;
      mv_q <= 1'b0;
    end else begin
      m_q  <= m_d;
      mv_q <= mv_d;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a queue model of held beats, checked against the
// DUT on every falling edge, plus directed scenarios with literal expectations.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 64;
  localparam logic [DW-1:0] FV = 64'h0BAD_F00D_0000_0000;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush;
  logic          freeze;
  logic [1:0]    occupancy;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(DW), .FLUSH_VAL(FV)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .freeze(freeze), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mq[$];     // held beats, oldest first
  logic [DW-1:0] last_head; // what the head register shows when empty

  function automatic bit m_in_ready();
    if (freeze) return 1'b0;
    if (CAP == 2) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  function automatic bit m_out_valid();
    return (mq.size() > 0) && !freeze;
  endfunction

  function automatic logic [DW-1:0] m_out_data();
    if (mq.size() > 0) return mq[0];
    return last_head;
  endfunction

  task automatic model_clear();
    mq.delete();
    last_head = FV;
  endtask

  always @(posedge clk) begin
    bit inf, outf;
    if (rst) begin
      model_clear();
    end else begin
      inf  = in_valid && m_in_ready();
      outf = m_out_valid() && out_ready;
      if (flush) begin
        model_clear();
      end else begin
        if (outf) last_head = mq.pop_front();
        if (inf) mq.push_back(in_data);
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("in_ready",  {63'd0, in_ready},  {63'd0, m_in_ready()});
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_out_valid()});
    chk("out_data",  out_data, m_out_data());
    chk("occupancy", {62'd0, occupancy}, DW'(mq.size()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a beat and hold it until accepted (bounded).
  task automatic send(input logic [DW-1:0] d);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    model_clear();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush = 1'b0; freeze = 1'b0;
    #12;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data",  out_data, FV);
    chk("rst_occupancy", {62'd0, occupancy}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    tick();

    // Stream 1..8 back to back with the sink always ready.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      tick();
      chk("stream_data",  out_data, DW'(i));
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    tick(); tick();

    // Backpressure.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hA; tick();
    in_data = 64'hB; tick();
    in_data = 64'hC;
    chk("bp_occupancy", {62'd0, occupancy}, DW'(CAP));
    chk("bp_in_ready",  {63'd0, in_ready}, 64'd0);
    tick();
    chk("bp_head", out_data, 64'hA);
    out_ready = 1'b1;
    send(64'hC);
    repeat (4) tick();

    // Flush with the stage full; the beat offered alongside is dropped.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h11; tick();
    in_data = 64'h12; tick();
    in_data = 64'hD; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_occupancy", {62'd0, occupancy}, 64'd0);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_out_data",  out_data, FV);
    out_ready = 1'b1;
    repeat (3) tick();

    // Freeze with one held beat.
    out_ready = 1'b0;
    send(64'h5);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_out_valid", {63'd0, out_valid}, 64'd0);
      chk("frz_in_ready",  {63'd0, in_ready}, 64'd0);
      chk("frz_occupancy", {62'd0, occupancy}, 64'd1);
      out_ready = i[0];
      tick();
    end
    freeze = 1'b0; out_ready = 1'b1;
    #1;
    chk("frz_release_valid", {63'd0, out_valid}, 64'd1);
    chk("frz_release_data",  out_data, 64'h5);
    tick();
    chk("frz_delivered_once", {62'd0, occupancy}, 64'd0);

    // Flush and freeze together.
    out_ready = 1'b0;
    send(64'h7);
    flush = 1'b1; freeze = 1'b1; tick();
    flush = 1'b0; freeze = 1'b0;
    chk("ff_occupancy", {62'd0, occupancy}, 64'd0);
    chk("ff_out_data",  out_data, FV);

    // Asynchronous reset between edges.
    send(64'h9);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_out_data",  out_data, FV);
    chk("arst_occupancy", {62'd0, occupancy}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 3);
      freeze    = ($urandom_range(0, 9) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; freeze = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
